// File: rtl/seg7_pkg.sv
// Shared types and constants for the seg7 scan multiplexer.
// Segment encodings are active-low in {dp,g,f,e,d,c,b,a} order.
package seg7_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    localparam int SEG_A  = 0;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    typedef enum logic {
        IDLE,
        PENDING
    } load_state_t;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low gfedcba segment pattern.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed common-anode 7-segment driver with shadow-buffered loads,
// brightness PWM, per-slot dead time and leading-zero suppression.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV_W = 10,
    parameter int BRIGHT_W   = 4,
    parameter int DEAD_CYC   = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    input  logic [NUM_DIGITS-1:0]   load_dp,
    input  logic [NUM_DIGITS-1:0]   load_blank,
    input  logic                    load_lz,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   digits,
    output logic [7:0]              number,
    output logic                    frame_tick
);

    localparam int SLOT_W = $clog2(NUM_DIGITS);
    localparam logic [SLOT_W-1:0]     LAST_SLOT = SLOT_W'(NUM_DIGITS - 1);
    localparam logic [SCAN_DIV_W-1:0] DEAD_LIM  = SCAN_DIV_W'(DEAD_CYC);

    logic [SCAN_DIV_W-1:0]   div;
    logic [SLOT_W-1:0]       slot;
    logic                    div_wrap;
    logic                    boundary;

    load_state_t             state;
    load_state_t             state_next;
    logic                    accept;
    logic                    transfer;

    logic [4*NUM_DIGITS-1:0] sh_value;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_blank;
    logic                    sh_lz;
    logic [NUM_DIGITS-1:0]   sup_mask;
    logic                    leading;

    logic [4*NUM_DIGITS-1:0] act_value;
    logic [NUM_DIGITS-1:0]   act_dp;
    logic [NUM_DIGITS-1:0]   act_blank;
    logic [NUM_DIGITS-1:0]   act_sup;
    logic [BRIGHT_W-1:0]     bright_q;

    logic [3:0]              cur_nibble;
    logic [6:0]              cur_seg;
    logic                    digit_on;
    logic [7:0]              num_on;

    assign div_wrap = (div == '1);
    assign boundary = div_wrap && (slot == LAST_SLOT);
    assign accept   = load_valid && load_ready;
    assign transfer = boundary && (state == PENDING);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            div  <= '0;
            slot <= '0;
        end else begin
            div <= div + 1'b1;
            if (div_wrap) begin
                slot <= (slot == LAST_SLOT) ? '0 : slot + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A load accepted on a boundary cycle is still IDLE there, so it waits a full frame.
    always_comb begin
        state_next = state;
        load_ready = 1'b0;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    state_next = PENDING;
                end
            end
            PENDING: begin
                if (boundary) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            sh_value <= '0;
            sh_dp    <= '0;
            sh_blank <= '0;
            sh_lz    <= 1'b0;
        end else if (accept) begin
            sh_value <= load_value;
            sh_dp    <= load_dp;
            sh_blank <= load_blank;
            sh_lz    <= load_lz;
        end
    end

    // Walk down from the MSB; the first nonzero nibble or lit dp ends the leading run.
    always_comb begin
        sup_mask = '0;
        leading  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (leading && (sh_value[4*i +: 4] == 4'h0) && !sh_dp[i]) begin
                sup_mask[i] = 1'b1;
            end else begin
                leading = 1'b0;
            end
        end
        if (!sh_lz) begin
            sup_mask = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            act_value <= '0;
            act_dp    <= '0;
            act_blank <= '1;
            act_sup   <= '0;
            bright_q  <= '0;
        end else begin
            if (boundary) begin
                bright_q <= brightness;
            end
            if (transfer) begin
                act_value <= sh_value;
                act_dp    <= sh_dp;
                act_blank <= sh_blank;
                act_sup   <= sup_mask;
            end
        end
    end

    assign cur_nibble = act_value[{slot, 2'b00} +: 4];

    seg7_hex_decode u_hex_decode (
        .nibble (cur_nibble),
        .seg    (cur_seg)
    );

    assign digit_on = (div >= DEAD_LIM)
                   && (div[SCAN_DIV_W-1 -: BRIGHT_W] <= bright_q)
                   && !act_blank[slot]
                   && !act_sup[slot];

    always_comb begin
        num_on                = SEG_OFF;
        num_on[SEG_DP]        = ~act_dp[slot];
        num_on[SEG_G:SEG_A]   = cur_seg;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            digits     <= '1;
            number     <= SEG_OFF;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= boundary;
            if (digit_on) begin
                digits <= ~(NUM_DIGITS'(1) << slot);
                number <= num_on;
            end else begin
                digits <= '1;
                number <= SEG_OFF;
            end
        end
    end

endmodule
